// File: rtl/usb_pkg.sv
// ============================================================================
//  Module   : usb_pkg
//  Purpose  : Shared USB line-state types and constants for the TX path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2
  } line_state_t;

  localparam int USB_EOP_SE0_BITS = 2;

  // Pad levels for a line state, returned as {dp, dm}
  function automatic logic [1:0] ls_pads(input line_state_t ls);
    case (ls)
      LS_J:    return 2'b10;
      LS_K:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/encode_nrzi_if.sv
// ============================================================================
//  Module   : encode_nrzi_if
//  Purpose  : Bit-stuffer to NRZI encoder/pad-driver signal bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface encode_nrzi_if;
  logic abort;
  logic bit_en;
  logic start_nrzi;
  logic s_in;
  logic end_nrzi;
  logic dp;
  logic dm;
  logic tx_oe;
  logic nrzi_wait;
  logic tx_done;

  modport master (
    output abort, bit_en, start_nrzi, s_in, end_nrzi,
    input  dp, dm, tx_oe, nrzi_wait, tx_done
  );

  modport slave (
    input  abort, bit_en, start_nrzi, s_in, end_nrzi,
    output dp, dm, tx_oe, nrzi_wait, tx_done
  );
endinterface

`default_nettype wire

// File: rtl/encode_nrzi_fsm.sv
// ============================================================================
//  Module   : nrzi_encode_fsm
//  Purpose  : Packet sequencing for the NRZI encoder (encode, EOP SE0/J).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module nrzi_encode_fsm #(
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_abort,
  input  logic i_bit_en,
  input  logic i_start,
  input  logic i_end,
  output logic o_upd,
  output logic o_load,
  output logic o_clr,
  output logic o_se0,
  output logic o_oe,
  output logic o_done,
  output logic o_wait
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENCODE  = 2'd1,
    ST_EOP_SE0 = 2'd2,
    ST_EOP_J   = 2'd3
  } state_t;

  localparam int                 c_cnt_w    = $clog2(EOP_SE0_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(EOP_SE0_BITS);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_step;
  logic w_cnt_last;
  logic w_load;
  logic w_clr;
  logic w_se0;
  logic w_oe;
  logic w_done;

  assign w_step     = i_bit_en & ~i_abort;
  assign w_cnt_last = (r_cnt == c_cnt_last);

  // Raw per-state controls describing the line for the next bit time
  always_comb begin
    w_load = 1'b0;
    w_clr  = 1'b0;
    w_se0  = 1'b0;
    w_oe   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load = i_start;
        w_oe   = i_start;
      end
      ST_ENCODE: begin
        w_oe   = 1'b1;
        w_se0  = i_end;
        w_load = ~i_end;
      end
      ST_EOP_SE0: begin
        w_oe  = 1'b1;
        w_clr = w_cnt_last;
        w_se0 = ~w_cnt_last;
      end
      default: begin
        w_done = 1'b1;
      end
    endcase
  end

  // Abort overrides everything: line forced to idle J with the driver off
  assign o_upd  = i_bit_en | i_abort;
  assign o_load = w_step & w_load;
  assign o_clr  = i_abort | (w_step & w_clr);
  assign o_se0  = ~i_abort & w_se0;
  assign o_oe   = ~i_abort & w_oe;
  assign o_done = w_step & w_done;
  assign o_wait = (r_state == ST_IDLE) & ~(i_start & i_bit_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_bit_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_ENCODE;
        end
        ST_ENCODE: begin
          if (i_end) begin
            r_state <= ST_EOP_SE0;
            r_cnt   <= c_cnt_one;
          end
        end
        ST_EOP_SE0: begin
          if (w_cnt_last) begin
            r_state <= ST_EOP_J;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/encode_nrzi.sv
// ============================================================================
//  Module   : encode_nrzi
//  Purpose  : USB TX NRZI encoder and line driver with EOP generation.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module encode_nrzi
  import usb_pkg::*;
#(
  parameter int EOP_SE0_BITS = USB_EOP_SE0_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  encode_nrzi_if.slave  bus
);

  logic        w_upd;
  logic        w_load;
  logic        w_clr;
  logic        w_se0;
  logic        w_oe;
  logic        w_done;
  logic        w_wait;
  logic        w_line_nxt;
  line_state_t w_ls_nxt;
  logic [1:0]  w_pads;

  logic r_line;
  logic r_dp;
  logic r_dm;
  logic r_oe;
  logic r_done;

  nrzi_encode_fsm #(
    .EOP_SE0_BITS (EOP_SE0_BITS)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_abort  (bus.abort),
    .i_bit_en (bus.bit_en),
    .i_start  (bus.start_nrzi),
    .i_end    (bus.end_nrzi),
    .o_upd    (w_upd),
    .o_load   (w_load),
    .o_clr    (w_clr),
    .o_se0    (w_se0),
    .o_oe     (w_oe),
    .o_done   (w_done),
    .o_wait   (w_wait)
  );

  // NRZI: a 1 holds the line level, a 0 toggles it
  always_comb begin
    w_line_nxt = r_line;
    if (w_clr) begin
      w_line_nxt = 1'b1;
    end else if (w_load) begin
      w_line_nxt = bus.s_in ? r_line : ~r_line;
    end
  end

  assign w_ls_nxt = w_se0 ? LS_SE0 : (w_line_nxt ? LS_J : LS_K);
  assign w_pads   = ls_pads(w_ls_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= 1'b1;
      r_dp   <= 1'b1;
      r_dm   <= 1'b0;
      r_oe   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_upd) begin
        r_line <= w_line_nxt;
        r_dp   <= w_pads[1];
        r_dm   <= w_pads[0];
        r_oe   <= w_oe;
      end
    end
  end

  assign bus.dp        = r_dp;
  assign bus.dm        = r_dm;
  assign bus.tx_oe     = r_oe;
  assign bus.tx_done   = r_done;
  assign bus.nrzi_wait = w_wait;

endmodule

`default_nettype wire

// File: tb/tb_encode_nrzi.sv
// ============================================================================
//  Module   : tb_encode_nrzi
//  Purpose  : Directed bench for encode_nrzi (EOP_SE0_BITS = 2 and 3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_encode_nrzi;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  encode_nrzi_if bus ();
  encode_nrzi_if bus3 ();

  encode_nrzi #(.EOP_SE0_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  encode_nrzi #(.EOP_SE0_BITS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct {
    logic       st;
    logic       s;
    logic       en;
    logic [3:0] exp;   // {dp, dm, tx_oe, tx_done}
  } vec_t;

  vec_t tbl [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {dp,dm,oe,done}=%b want %b", name, act, exp);
    end
  endtask

  task automatic check_wait(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: nrzi_wait got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs(input bit sel3);
    if (sel3) return {bus3.dp, bus3.dm, bus3.tx_oe, bus3.tx_done};
    return {bus.dp, bus.dm, bus.tx_oe, bus.tx_done};
  endfunction

  task automatic drive(input bit sel3, input logic be, input logic st, input logic s,
                       input logic en, input logic ab);
    if (sel3) begin
      bus3.bit_en = be; bus3.start_nrzi = st; bus3.s_in = s;
      bus3.end_nrzi = en; bus3.abort = ab;
    end else begin
      bus.bit_en = be; bus.start_nrzi = st; bus.s_in = s;
      bus.end_nrzi = en; bus.abort = ab;
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One bit time: bit_en for one clk, then three idle clks
  task automatic strobe(input bit sel3, input logic st, input logic s, input logic en,
                        input string name, input logic [3:0] exp);
    drive(sel3, 1'b1, st, s, en, 1'b0);
    clk1();
    drive(sel3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check(name, outs(sel3), exp);
    clk1();
    check({name, "_hold"}, outs(sel3), {exp[3:1], 1'b0});
    clk1();
    clk1();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      strobe(1'b0, tbl[i].st, tbl[i].s, tbl[i].en, $sformatf("%s_%0d", tag, i), tbl[i].exp);
      if (i == 0) check_wait({tag, "_wait_enc"}, bus.nrzi_wait, 1'b0);
    end
    check_wait({tag, "_wait_idle"}, bus.nrzi_wait, 1'b1);
  endtask

  initial begin
    // start s=0 -> K, then 0,1,1,0 -> J,J,J,K, end -> SE0,SE0,J, then done
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0110};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 4'b1010};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b1010};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'b1010};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'b0110};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'b0010};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0010};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'b1010};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 4'b1001};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) clk1();
    check("rst", outs(1'b0), 4'b1000);
    check("rst3", outs(1'b1), 4'b1000);
    check_wait("rst_wait", bus.nrzi_wait, 1'b1);
    rst_n = 1'b1;
    clk1();
    check("post_rst", outs(1'b0), 4'b1000);

    // Basic packet, then a second one on the very next bit_en
    run_table("pkt");
    run_table("b2b");

    // Abort during the second SE0 bit
    strobe(1'b0, 1'b1, 1'b1, 1'b0, "ab_start", 4'b1010);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, "ab_se0a", 4'b0010);
    strobe(1'b0, 1'b0, 1'b0, 1'b0, "ab_se0b", 4'b0010);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clk1();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_clr", outs(1'b0), 4'b1000);
    check_wait("abort_wait", bus.nrzi_wait, 1'b1);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("ab_idle_%0d", i), 4'b1000);
    run_table("post_ab");

    // Abort in IDLE
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clk1();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_idle", outs(1'b0), 4'b1000);

    // Inputs without bit_en, end in IDLE, start+end together
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    clk1();
    clk1();
    check("no_be", outs(1'b0), 4'b1000);
    check_wait("no_be_wait", bus.nrzi_wait, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, "end_idle", 4'b1000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check_wait("start_wait", bus.nrzi_wait, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, 1'b1, "st_en", 4'b0110);
    strobe(1'b0, 1'b1, 1'b1, 1'b0, "enc_ign_start", 4'b0110);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    clk1();
    clk1();
    check("enc_no_be", outs(1'b0), 4'b0110);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, "st_en_se0a", 4'b0010);
    strobe(1'b0, 1'b0, 1'b0, 1'b0, "st_en_se0b", 4'b0010);
    strobe(1'b0, 1'b0, 1'b0, 1'b0, "st_en_j", 4'b1010);
    strobe(1'b0, 1'b0, 1'b0, 1'b0, "st_en_done", 4'b1001);

    // Three-bit SE0 build
    strobe(1'b1, 1'b1, 1'b1, 1'b0, "p3_start", 4'b1010);
    strobe(1'b1, 1'b0, 1'b0, 1'b1, "p3_se0a", 4'b0010);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "p3_se0b", 4'b0010);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "p3_se0c", 4'b0010);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "p3_j", 4'b1010);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, "p3_done", 4'b1001);

    // Asynchronous reset mid-packet, away from any clock edge
    strobe(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_k", 4'b0110);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", outs(1'b0), 4'b1000);
    clk1();
    rst_n = 1'b1;
    clk1();
    strobe(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_idle", 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
